fetch_sequencer: RTL and testbench

- Instruction fetch and sequencing controller for the 8-bit Harvard CPU.
- Owns the program counter and drives the asynchronous-read program memory (8-bit address in, 8-bit data out, same-cycle combinational read).
- Assembles variable-length instructions (opcode byte plus 0–2 operand bytes) and issues them to the execute unit over a valid/ready handshake.
- Resolves JMP and HLT internally; accepts branch redirects from execute.

---
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch and sequencing controller for the 8-bit Harvard CPU.
// Walks the program counter over asynchronous-read program memory, gathers
// an opcode plus up to two operand bytes, and hands the assembled instruction
// to the execute unit over a valid/ready handshake. JMP and HLT are resolved
// here. Taken branches arrive from execute on the redirect port.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OP  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] pm_addr,
  input  logic [7:0] pm_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_op,
  output logic [7:0] instr_a,
  output logic [7:0] instr_b,
  output logic [1:0] instr_len,
  output logic [7:0] instr_pc,
  output logic       illegal,
  input  logic       redirect,
  input  logic [7:0] redirect_addr,
  input  logic       resume,
  output logic       halted
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MOV = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_A,
    FETCH_B,
    ISSUE,
    HALT
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] pc_inc;
  logic [1:0] dec_ops;
  logic       dec_illegal;

  // The memory address is the PC register itself, so it never glitches.
  assign pm_addr = pc;
  assign pc_inc  = pc + 8'd1;

  // Decode the operand count of the byte currently on pm_data (used in FETCH_OP).
  always_comb begin
    dec_ops     = 2'd0;
    dec_illegal = 1'b0;
    case (pm_data)
      OP_NOP:                 dec_ops = 2'd0;
      OP_ADD, OP_SUB, OP_MOV: dec_ops = 2'd2;
      OP_JMP:                 dec_ops = 2'd1;
      default:                dec_illegal = (pm_data != HALT_OP);
    endcase
  end

  // Sequencer: one byte per fetch state, redirect overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_OP;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_op    <= 8'h00;
      instr_a     <= 8'h00;
      instr_b     <= 8'h00;
      instr_len   <= 2'd0;
      instr_pc    <= 8'h00;
      illegal     <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_addr;
      state       <= FETCH_OP;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          instr_op  <= pm_data;
          instr_pc  <= pc;
          instr_a   <= 8'h00;
          instr_b   <= 8'h00;
          instr_len <= dec_ops + 2'd1;
          illegal   <= dec_illegal;
          pc        <= pc_inc;
          if (pm_data == HALT_OP) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (dec_ops == 2'd0) begin
            state       <= ISSUE;
            instr_valid <= 1'b1;
          end else begin
            state <= FETCH_A;
          end
        end
        FETCH_A: begin
          instr_a <= pm_data;
          if (instr_op == OP_JMP) begin
            pc    <= pm_data;
            state <= FETCH_OP;
          end else begin
            pc <= pc_inc;
            if (instr_len == 2'd2) begin
              state       <= ISSUE;
              instr_valid <= 1'b1;
            end else begin
              state <= FETCH_B;
            end
          end
        end
        FETCH_B: begin
          instr_b     <= pm_data;
          pc          <= pc_inc;
          state       <= ISSUE;
          instr_valid <= 1'b1;
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH_OP;
          end
        end
        HALT: begin
          if (resume) begin
            halted <= 1'b0;
            state  <= FETCH_OP;
          end
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: a small program memory array feeds
// the DUT and each step checks hand-computed expected outputs.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_a;
  logic [7:0] instr_b;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic       illegal;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       resume;
  logic       halted;

  logic [7:0] mem [256];
  int total;
  int bad;

  fetch_sequencer #(.RESET_PC(8'h00), .HALT_OP(8'hFF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pm_addr(pm_addr),
    .pm_data(pm_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op(instr_op),
    .instr_a(instr_a),
    .instr_b(instr_b),
    .instr_len(instr_len),
    .instr_pc(instr_pc),
    .illegal(illegal),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .resume(resume),
    .halted(halted)
  );

  // Asynchronous program memory model.
  assign pm_data = mem[pm_addr];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic apply_stimulus_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b1;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 8'h00;
    resume        = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h07; mem[2] = 8'h02; mem[3] = 8'hFF;

    // Reset values while rst_n is held low.
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_pm_addr", pm_addr, 8'h00);
    check_bit("rst_valid", instr_valid, 1'b0);
    check_output("rst_op", instr_op, 8'h00);
    check_output("rst_len", {6'b0, instr_len}, 8'h00);
    check_output("rst_pc", instr_pc, 8'h00);
    check_bit("rst_illegal", illegal, 1'b0);
    check_bit("rst_halted", halted, 1'b0);
    #9;
    rst_n = 1'b1;

    // Three-byte ADD with ready high, then HLT.
    $display("[TB] step: ADD then HLT");
    instr_ready = 1'b1;
    tick();
    tick();
    check_bit("add_lat_c3", instr_valid, 1'b0);
    tick();
    check_bit("add_valid", instr_valid, 1'b1);
    check_output("add_op", instr_op, 8'h01);
    check_output("add_a", instr_a, 8'h07);
    check_output("add_b", instr_b, 8'h02);
    check_output("add_len", {6'b0, instr_len}, 8'h03);
    check_output("add_pc", instr_pc, 8'h00);
    check_bit("add_illegal", illegal, 1'b0);
    tick();
    check_bit("add_accepted", instr_valid, 1'b0);
    tick();
    check_bit("hlt_halted", halted, 1'b1);
    check_output("hlt_pm_addr", pm_addr, 8'h04);
    tick();
    tick();
    check_output("hlt_pm_stable", pm_addr, 8'h04);
    check_bit("hlt_no_valid", instr_valid, 1'b0);

    // Same program with backpressure: outputs hold while ready is low.
    $display("[TB] step: backpressure");
    instr_ready = 1'b0;
    apply_stimulus_reset();
    tick();
    tick();
    tick();
    check_bit("bp_valid", instr_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bit("bp_hold_valid", instr_valid, 1'b1);
      check_output("bp_hold_pm_addr", pm_addr, 8'h03);
    end
    check_output("bp_hold_op", instr_op, 8'h01);
    check_output("bp_hold_a", instr_a, 8'h07);
    check_output("bp_hold_b", instr_b, 8'h02);
    check_output("bp_hold_len", {6'b0, instr_len}, 8'h03);
    instr_ready = 1'b1;
    tick();
    check_bit("bp_accept", instr_valid, 1'b0);
    check_output("bp_next_addr", pm_addr, 8'h03);
    tick();
    check_bit("bp_halted", halted, 1'b1);

    // JMP is resolved internally and never issued.
    $display("[TB] step: JMP");
    mem[8'h00] = 8'h04; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h00; mem[8'h11] = 8'hFF;
    apply_stimulus_reset();
    tick();
    check_bit("jmp_c1_valid", instr_valid, 1'b0);
    tick();
    check_bit("jmp_c2_valid", instr_valid, 1'b0);
    check_output("jmp_target", pm_addr, 8'h10);
    tick();
    check_bit("nop_valid", instr_valid, 1'b1);
    check_output("nop_op", instr_op, 8'h00);
    check_output("nop_len", {6'b0, instr_len}, 8'h01);
    check_output("nop_pc", instr_pc, 8'h10);
    tick();
    tick();
    check_bit("jmp_halted", halted, 1'b1);
    check_output("jmp_halt_addr", pm_addr, 8'h12);

    // Instruction straddling the PC wrap, reached via redirect out of HALT.
    $display("[TB] step: wrap");
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h07; mem[8'h00] = 8'h02; mem[8'h01] = 8'hFF;
    redirect      = 1'b1;
    redirect_addr = 8'hFE;
    tick();
    redirect = 1'b0;
    check_bit("wrap_unhalt", halted, 1'b0);
    check_output("wrap_start", pm_addr, 8'hFE);
    tick();
    tick();
    check_output("wrap_pc_00", pm_addr, 8'h00);
    tick();
    check_bit("wrap_valid", instr_valid, 1'b1);
    check_output("wrap_op", instr_op, 8'h01);
    check_output("wrap_a", instr_a, 8'h07);
    check_output("wrap_b", instr_b, 8'h02);
    check_output("wrap_ipc", instr_pc, 8'hFE);
    check_output("wrap_pm_addr", pm_addr, 8'h01);
    tick();
    tick();
    check_bit("wrap_halted", halted, 1'b1);

    // Redirect during FETCH_A discards the partial ADD.
    $display("[TB] step: redirect");
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h07; mem[8'h02] = 8'h02;
    mem[8'h20] = 8'h00;
    mem[8'h30] = 8'h7E; mem[8'h31] = 8'hFF; mem[8'h32] = 8'h00; mem[8'h33] = 8'hFF;
    apply_stimulus_reset();
    tick();
    redirect      = 1'b1;
    redirect_addr = 8'h20;
    tick();
    redirect = 1'b0;
    check_bit("redir_no_valid", instr_valid, 1'b0);
    check_output("redir_addr", pm_addr, 8'h20);
    tick();
    check_bit("redir_nop_valid", instr_valid, 1'b1);
    check_output("redir_nop_op", instr_op, 8'h00);
    check_output("redir_nop_pc", instr_pc, 8'h20);

    // Redirect coinciding with an accepted issue.
    redirect      = 1'b1;
    redirect_addr = 8'h30;
    tick();
    redirect = 1'b0;
    check_bit("coin_valid_drop", instr_valid, 1'b0);
    check_output("coin_addr", pm_addr, 8'h30);

    // Illegal opcode issues as a one-byte instruction.
    tick();
    check_bit("ill_valid", instr_valid, 1'b1);
    check_bit("ill_flag", illegal, 1'b1);
    check_output("ill_op", instr_op, 8'h7E);
    check_output("ill_len", {6'b0, instr_len}, 8'h01);
    check_output("ill_pc", instr_pc, 8'h30);
    tick();
    tick();
    check_bit("ill_halted", halted, 1'b1);
    check_output("ill_halt_addr", pm_addr, 8'h32);

    // Resume restarts at the byte after HLT.
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check_bit("resume_unhalt", halted, 1'b0);
    check_output("resume_addr", pm_addr, 8'h32);
    tick();
    check_bit("resume_valid", instr_valid, 1'b1);
    check_output("resume_op", instr_op, 8'h00);
    check_output("resume_pc", instr_pc, 8'h32);
    check_bit("resume_illegal", illegal, 1'b0);
    tick();
    tick();
    check_bit("resume_halted", halted, 1'b1);

    // Redirect wins over resume in HALT.
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h07; mem[8'h42] = 8'h02;
    resume        = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 8'h40;
    tick();
    resume   = 1'b0;
    redirect = 1'b0;
    check_output("prio_addr", pm_addr, 8'h40);
    check_bit("prio_unhalt", halted, 1'b0);

    // Asynchronous reset in the middle of FETCH_B.
    $display("[TB] step: async reset");
    tick();
    tick();
    check_output("midb_a", instr_a, 8'h07);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_pm_addr", pm_addr, 8'h00);
    check_output("areset_op", instr_op, 8'h00);
    check_output("areset_a", instr_a, 8'h00);
    check_bit("areset_valid", instr_valid, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_output("areset_restart", pm_addr, 8'h01);
    check_output("areset_op_new", instr_op, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
